mem_burst_scheduler: RTL and testbench

- Shares one single-ported on-chip buffer/SRAM port between NUM_PORTS requesters (PE array loaders, weight fetch, result drain).
- Each requester asks for one burst of 1..2^LEN_W beats.
- Grants go round-robin, one burst at a time, and the grant is held until the burst completes.
- Drives the buffer-side beat handshake and sequences the beat count.

---
 rtl/mem_sched_pkg.sv | 38 +++
 rtl/rr_pointer_pick.sv | 24 ++
 rtl/mem_burst_scheduler.sv | 164 ++++++++++++++++
 tb/tb_mem_burst_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the memory burst scheduler.
// Holds parameter defaults, the FSM state type and the round-robin search
// function used by rr_pointer_pick.
package mem_sched_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_LEN_W     = 4;
    localparam int DEF_MAX_WAIT  = 15;

    // Upper bound on requesters the search function supports.
    localparam int MAX_PORTS = 32;
    localparam int IDX_W     = $clog2(MAX_PORTS);

    typedef enum logic [0:0] {S_IDLE, S_BURST} sched_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req scanning last+1, last+2, ... modulo num_ports.
    function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                      input int last,
                                      input int num_ports);
        pick_t            r;
        logic [IDX_W-1:0] i;
        r = '0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            i = IDX_W'((last + k) % num_ports);
            if (k <= num_ports && !r.found && req[i]) begin
                r.found = 1'b1;
                r.idx   = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pointer_pick.sv
// Combinational rotate-and-find-first picker: returns the first requesting
// port after the round-robin pointer, with wrap-around.
module rr_pointer_pick
    import mem_sched_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int SEL_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_WIDTH-1:0] last,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx
);

    pick_t pick;

    // Search the rotated request vector for the next owner.
    always_comb begin
        pick  = rr_pick(MAX_PORTS'(req), int'(last), NUM_PORTS);
        found = pick.found;
        idx   = SEL_WIDTH'(pick.idx);
    end

endmodule

// File: rtl/mem_burst_scheduler.sv
// Round-robin burst scheduler for a single-ported on-chip buffer.
// One requester owns the port for a whole burst; one idle cycle separates
// consecutive grants so the buffer mux can switch.
// Optional starvation guard: define MEM_SCHED_STARVE_GUARD_EN to add per-port
// wait counters, urgent-first arbitration and the starved output.
module mem_burst_scheduler
    import mem_sched_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int SEL_WIDTH = $clog2(NUM_PORTS),
    parameter int LEN_W     = DEF_LEN_W,
    parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       req,
    input  logic [NUM_PORTS*LEN_W-1:0] req_len,
    output logic [NUM_PORTS-1:0]       grant,
    output logic [SEL_WIDTH-1:0]       select,
    output logic                       busy,
    output logic                       beat_valid,
    output logic                       beat_last,
    input  logic                       beat_ready,
    output logic [NUM_PORTS-1:0]       done
`ifdef MEM_SCHED_STARVE_GUARD_EN
    ,
    output logic                       starved
`endif
);

    sched_state_e         state, state_next;
    logic [LEN_W-1:0]     cnt;
    logic [SEL_WIDTH-1:0] last;
    logic                 rr_found;
    logic [SEL_WIDTH-1:0] rr_idx;
    logic [SEL_WIDTH-1:0] win;
    logic                 accept;
    logic                 take;
    logic                 finish;

    rr_pointer_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_pick (
        .req   (req),
        .last  (last),
        .found (rr_found),
        .idx   (rr_idx)
    );

    assign busy       = (state == S_BURST);
    assign beat_valid = busy;
    assign beat_last  = busy && (cnt == '0);
    assign accept     = beat_valid && beat_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and grant/finish strobes.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rr_found) begin
                    take       = 1'b1;
                    state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (accept && cnt == '0) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Ownership, beat counter, round-robin pointer and done pulse.
    // Reset mid-burst clears everything at once, so no done pulse escapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant  <= '0;
            select <= '0;
            cnt    <= '0;
            last   <= SEL_WIDTH'(NUM_PORTS - 1);
            done   <= '0;
        end else begin
            done <= '0;
            if (take) begin
                select <= win;
                grant  <= NUM_PORTS'(1) << win;
                cnt    <= req_len[win*LEN_W +: LEN_W];
                last   <= win;
            end else if (finish) begin
                grant <= '0;
                done  <= NUM_PORTS'(1) << select;
            end else if (accept) begin
                cnt <= cnt - LEN_W'(1);
            end
        end
    end

`ifdef MEM_SCHED_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1) + 1;

    logic [WAIT_W-1:0]    wait_cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] urgent;
    logic                 urg_found;
    logic [SEL_WIDTH-1:0] urg_idx;

    // Ports that have waited at least MAX_WAIT cycles are urgent.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            urgent[i] = req[i] && (wait_cnt[i] >= WAIT_W'(MAX_WAIT));
        end
    end

    rr_pointer_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_urgent_pick (
        .req   (urgent),
        .last  (last),
        .found (urg_found),
        .idx   (urg_idx)
    );

    assign win = urg_found ? urg_idx : rr_idx;

    // Saturating wait counters, cleared when the port is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (take && win == SEL_WIDTH'(i))
                    wait_cnt[i] <= '0;
                else if (req[i] && !grant[i] && wait_cnt[i] != '1)
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
            end
        end
    end

    // One-cycle flag alongside a grant won through urgency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starved <= 1'b0;
        else     starved <= take && urg_found;
    end
`else
    logic unused_max_wait;

    assign win             = rr_idx;
    assign unused_max_wait = ^MAX_WAIT;
`endif

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Self-checking bench for mem_burst_scheduler: per-cycle vector table plus
// hand-written burst-length, late req_len and starvation sequences.
`timescale 1ns/1ps
module tb_mem_burst_scheduler;

    localparam int NP = 4;
    localparam int LW = 4;
`ifdef MEM_SCHED_STARVE_GUARD_EN
    localparam int MW = 3;
`else
    localparam int MW = 15;
`endif

    logic          clk;
    logic          rst;
    logic [NP-1:0] req;
    logic [15:0]   req_len;
    logic [NP-1:0] grant;
    logic [1:0]    select;
    logic          busy;
    logic          beat_valid;
    logic          beat_last;
    logic          beat_ready;
    logic [NP-1:0] done;
`ifdef MEM_SCHED_STARVE_GUARD_EN
    logic          starved;
`endif

    mem_burst_scheduler #(
        .NUM_PORTS (NP),
        .LEN_W     (LW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .grant      (grant),
        .select     (select),
        .busy       (busy),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .beat_ready (beat_ready),
        .done       (done)
`ifdef MEM_SCHED_STARVE_GUARD_EN
        ,
        .starved    (starved)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic        rdy;
        logic [3:0]  g;
        logic [1:0]  sel;
        logic        b;
        logic        l;
        logic [3:0]  d;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] q, input logic [15:0] ln,
                                input logic rd, input logic [3:0] g, input logic [1:0] s,
                                input logic b, input logic l, input logic [3:0] d);
        vec_t v;
        v.rst = r; v.req = q; v.len = ln; v.rdy = rd;
        v.g = g; v.sel = s; v.b = b; v.l = l; v.d = d;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; req_len = '0; beat_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single burst from one port; optionally rewrite req_len after the grant.
    task automatic burst_seq(input int p, input logic [3:0] len, input logic [3:0] late,
                             input int exp_beats, input string name);
        int   beats;
        logic seen_last;
        do_reset();
        @(negedge clk);
        req = 4'(1) << p; req_len = 16'(len) << (p * 4); beat_ready = 1'b1;
        @(negedge clk); #1;
        check({name, " grant"}, 32'(grant), 32'(4'(1) << p));
        check({name, " select"}, 32'(select), p);
        req_len = 16'(late) << (p * 4);
        beats = 0; seen_last = 1'b0;
        for (int n = 0; n < 40 && !seen_last; n++) begin
            if (busy) beats++;
            if (beat_last) seen_last = 1'b1;
            else begin
                @(negedge clk); #1;
            end
        end
        check({name, " last seen"}, 32'(seen_last), 1);
        check({name, " beats"}, beats, exp_beats);
        @(negedge clk); #1;
        req = '0;
        check({name, " done"}, 32'(done), 32'(4'(1) << p));
        check({name, " busy after"}, 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_len = '0; beat_ready = 1'b1;

        // Single port, len=3: four beats, last on the 4th, done next cycle.
        add(1'b1, 4'h0, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0003, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0003, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0003, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0003, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0003, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'h0, 16'h0003, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h1);
        add(1'b0, 4'h0, 16'h0003, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        // All ports, len=0: order 0,1,2,3,0 with a bubble between grants.
        add(1'b1, 4'h0, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h1);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h2, 2'd1, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0, 4'h2);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h4, 2'd2, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 2'd2, 1'b0, 1'b0, 4'h4);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h8, 2'd3, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 2'd3, 1'b0, 1'b0, 4'h8);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h1);
        add(1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        // beat_ready 1,0,1,0 with len=1: last held through the stall.
        add(1'b1, 4'h0, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0001, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0001, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0001, 1'b0, 4'h1, 2'd0, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'h1, 16'h0001, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'h0, 16'h0001, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 4'h1);
        add(1'b0, 4'h0, 16'h0001, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        // Reset on the 2nd beat of a len=7 burst: outputs clear at once,
        // no done, port 0 wins first afterwards.
        add(1'b1, 4'h0, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0007, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'h1, 16'h0007, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 4'h0);
        add(1'b1, 4'h1, 16'h0007, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'hF, 16'h0000, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h1);
        add(1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; req = vecs[i].req;
            req_len = vecs[i].len; beat_ready = vecs[i].rdy;
            #1;
            check($sformatf("v%0d grant", i),      32'(grant),      32'(vecs[i].g));
            check($sformatf("v%0d select", i),     32'(select),     32'(vecs[i].sel));
            check($sformatf("v%0d busy", i),       32'(busy),       32'(vecs[i].b));
            check($sformatf("v%0d beat_valid", i), 32'(beat_valid), 32'(vecs[i].b));
            check($sformatf("v%0d beat_last", i),  32'(beat_last),  32'(vecs[i].l));
            check($sformatf("v%0d done", i),       32'(done),       32'(vecs[i].d));
        end

        // Maximum length on port 2: 16 beats, counter does not wrap.
        burst_seq(2, 4'hF, 4'hF, 16, "maxlen");
        // req_len rewritten 2 -> 9 after grant on port 1: still 3 beats.
        burst_seq(1, 4'h2, 4'h9, 3, "latelen");

        // Port 3 waits behind a long port-0 burst; ports 1,2 arrive late.
        begin
            logic seen;
            do_reset();
            @(negedge clk);
            req = 4'b1001; req_len = 16'h7777; beat_ready = 1'b1;
            @(negedge clk); #1;
            check("starve first grant", 32'(grant), 32'h1);
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                if (beat_last) seen = 1'b1;
                else begin
                    @(negedge clk); #1;
                end
            end
            check("starve last seen", 32'(seen), 1);
            req = 4'b1111;
            @(negedge clk); #1;
            check("starve done0", 32'(done), 32'h1);
            req = 4'b1110;
            @(negedge clk); #1;
`ifdef MEM_SCHED_STARVE_GUARD_EN
            check("starve urgent grant", 32'(grant), 32'h8);
            check("starve select", 32'(select), 3);
            check("starved pulse", 32'(starved), 1);
            @(negedge clk); #1;
            check("starved cleared", 32'(starved), 0);
`else
            check("rr grant", 32'(grant), 32'h2);
            check("rr select", 32'(select), 1);
`endif
            req = '0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
